// File: rtl/usg_tcam_pkg.sv
// usg_tcam_pkg: cfg_sel encodings and rule geometry shared by the param_tcam slice
package usg_tcam_pkg;

    localparam logic [7:0] SEL_CTRL      = 8'h00;
    localparam logic [7:0] SEL_CNT       = 8'h01;
    localparam logic [7:0] SEL_KEY_BASE  = 8'h10;
    localparam logic [7:0] SEL_MASK_BASE = 8'h20;

    function automatic int rule_words(input int w_key);
        return (w_key + 31) / 32;
    endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// tcam_prio_enc: lowest-index priority encoder over a rule match bitmap
module tcam_prio_enc #(
    parameter int N_RULES = 16
) (
    input  logic [N_RULES-1:0]         match,
    output logic                       hit,
    output logic [$clog2(N_RULES)-1:0] idx
);
    localparam int IW = $clog2(N_RULES);

    always_comb begin
        idx = '0;
        for (int i = N_RULES - 1; i >= 0; i--)
            if (match[i]) idx = IW'(i);
    end

    assign hit = |match;

endmodule

// File: rtl/param_tcam.sv
// param_tcam: ternary match table with a 2-stage lookup pipeline and a 32-bit config port.
// Define PARAM_TCAM_COUNTER_EN to build per-rule saturating hit counters (cfg_sel 0x01).
module param_tcam
    import usg_tcam_pkg::*;
#(
    parameter int N_RULES  = 16,
    parameter int W_KEY    = 104,
    parameter int W_RULEID = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       key_valid,
    input  logic [W_KEY-1:0]           key,
    output logic                       key_ready,
    output logic                       ruleID_valid,
    output logic [W_RULEID-1:0]        ruleID,
    output logic                       hit,
    input  logic                       s_out_ready,
    input  logic                       cfg_valid,
    input  logic                       cfg_wr,
    input  logic [$clog2(N_RULES)-1:0] cfg_rule,
    input  logic [7:0]                 cfg_sel,
    input  logic [31:0]                cfg_wdata,
    output logic                       cfg_rsp_valid,
    output logic [31:0]                cfg_rdata
);
    localparam int IW      = $clog2(N_RULES);
    localparam int N_WORDS = rule_words(W_KEY);
    localparam int PADW    = N_WORDS * 32;
    localparam int WIW     = N_WORDS > 1 ? $clog2(N_WORDS) : 1;

    typedef logic [N_WORDS-1:0][31:0] words_t;

    // Bits above W_KEY are never stored, so they read back as zero and never match.
    localparam words_t KEEP = PADW'({W_KEY{1'b1}});

    logic [N_RULES-1:0] valid_q, valid_d;
    words_t             keyval_q [N_RULES];
    words_t             keyval_d [N_RULES];
    words_t             mask_q   [N_RULES];
    words_t             mask_d   [N_RULES];
    logic               s1_valid_q, s1_valid_d;
    logic [N_RULES-1:0] match_q, match_d, match_now;
    logic               rid_valid_q, rid_valid_d;
    logic               hit_q, hit_d;
    logic [W_RULEID-1:0] rid_q, rid_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               enc_hit;
    logic [IW-1:0]      enc_idx;
    logic [WIW-1:0]     wi;
    logic               wr_en, rd_en, word_ok;
    logic               sel_ctrl, sel_key, sel_mask, sel_cnt;
    logic [31:0]        cnt_rd;
    words_t             key_pad;

    assign key_ready = !(rid_valid_q && !s_out_ready);
    assign wr_en     = cfg_valid && cfg_wr;
    assign rd_en     = cfg_valid && !cfg_wr;
    assign wi        = cfg_sel[WIW-1:0];
    assign word_ok   = {4'b0, cfg_sel[3:0]} < 8'(N_WORDS);
    assign sel_ctrl  = cfg_sel == SEL_CTRL;
    assign sel_key   = cfg_sel[7:4] == SEL_KEY_BASE[7:4] && word_ok;
    assign sel_mask  = cfg_sel[7:4] == SEL_MASK_BASE[7:4] && word_ok;
    assign key_pad   = PADW'(key);

    always_comb begin
        valid_d  = valid_q;
        keyval_d = keyval_q;
        mask_d   = mask_q;
        if (wr_en && sel_ctrl) valid_d[cfg_rule] = cfg_wdata[0];
        if (wr_en && sel_key) keyval_d[cfg_rule][wi] = cfg_wdata & KEEP[wi];
        if (wr_en && sel_mask) mask_d[cfg_rule][wi] = cfg_wdata & KEEP[wi];
    end

    always_comb begin
        for (int r = 0; r < N_RULES; r++)
            match_now[r] = valid_q[r] && ((key_pad ^ keyval_q[r]) & mask_q[r]) == '0;
    end

    tcam_prio_enc #(.N_RULES(N_RULES)) u_prio_enc (
        .match (match_q),
        .hit   (enc_hit),
        .idx   (enc_idx)
    );

    // Both stages move together; a stall freezes the whole pipe.
    always_comb begin
        s1_valid_d  = key_ready ? key_valid : s1_valid_q;
        match_d     = key_ready ? match_now : match_q;
        rid_valid_d = key_ready ? s1_valid_q : rid_valid_q;
        hit_d       = key_ready ? s1_valid_q && enc_hit : hit_q;
        rid_d       = key_ready ? (s1_valid_q && enc_hit ? W_RULEID'(enc_idx) : '1) : rid_q;
    end

    always_comb begin
        rsp_valid_d = rd_en;
        rdata_d     = !rd_en   ? '0 :
                      sel_ctrl ? {31'b0, valid_q[cfg_rule]} :
                      sel_key  ? keyval_q[cfg_rule][wi] :
                      sel_mask ? mask_q[cfg_rule][wi] :
                      sel_cnt  ? cnt_rd : '0;
    end

`ifdef PARAM_TCAM_COUNTER_EN
    logic [31:0]   cnt_q [N_RULES];
    logic [31:0]   cnt_d [N_RULES];
    logic [IW-1:0] inc_idx;
    logic          inc_en;

    assign sel_cnt = cfg_sel == SEL_CNT;
    assign cnt_rd  = cnt_q[cfg_rule];
    assign inc_idx = rid_q[IW-1:0];
    assign inc_en  = rid_valid_q && hit_q && s_out_ready;

    // The config write is applied last so it overrides a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_en && cnt_q[inc_idx] != '1) cnt_d[inc_idx] = cnt_q[inc_idx] + 32'd1;
        if (wr_en && sel_cnt) cnt_d[cfg_rule] = cfg_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_RULES; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign sel_cnt = 1'b0;
    assign cnt_rd  = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < N_RULES; i++) begin
                keyval_q[i] <= '0;
                mask_q[i]   <= '0;
            end
            s1_valid_q  <= 1'b0;
            match_q     <= '0;
            rid_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            rid_q       <= '1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            keyval_q    <= keyval_d;
            mask_q      <= mask_d;
            s1_valid_q  <= s1_valid_d;
            match_q     <= match_d;
            rid_valid_q <= rid_valid_d;
            hit_q       <= hit_d;
            rid_q       <= rid_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign ruleID_valid  = rid_valid_q;
    assign ruleID        = rid_q;
    assign hit           = hit_q;
    assign cfg_rsp_valid = rsp_valid_q;
    assign cfg_rdata     = rdata_q;

endmodule

// File: tb/tb_param_tcam.sv
// tb_param_tcam: randomized and directed lookups/config checked against a rule-table model
module tb_param_tcam;
    localparam int NR = 16;
`ifdef PARAM_TCAM_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] id;
        logic        hit;
        int          acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         key_valid = 1'b0;
    logic [103:0] key = '0;
    logic         key_ready;
    logic         ruleID_valid;
    logic [15:0]  ruleID;
    logic         hit;
    logic         s_out_ready = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_wr = 1'b0;
    logic [3:0]   cfg_rule = '0;
    logic [7:0]   cfg_sel = '0;
    logic [31:0]  cfg_wdata = '0;
    logic         cfg_rsp_valid;
    logic [31:0]  cfg_rdata;

    logic         m_valid [NR];
    logic [103:0] m_key   [NR];
    logic [103:0] m_mask  [NR];
    logic [31:0]  m_cnt   [NR];
    exp_t         q [$];
    int           cyc, n_checks, n_fail;
    bit           lat_check, seen_valid;
    logic         rsp_v, kr_s, last_hit;
    logic [15:0]  last_id;
    logic [31:0]  rsp_d, rd_exp;

    always #5 clk = ~clk;

    param_tcam dut (
        .clk           (clk),
        .reset         (reset),
        .key_valid     (key_valid),
        .key           (key),
        .key_ready     (key_ready),
        .ruleID_valid  (ruleID_valid),
        .ruleID        (ruleID),
        .hit           (hit),
        .s_out_ready   (s_out_ready),
        .cfg_valid     (cfg_valid),
        .cfg_wr        (cfg_wr),
        .cfg_rule      (cfg_rule),
        .cfg_sel       (cfg_sel),
        .cfg_wdata     (cfg_wdata),
        .cfg_rsp_valid (cfg_rsp_valid),
        .cfg_rdata     (cfg_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [103:0] rand104();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[103:0];
    endfunction

    function automatic exp_t model_lookup(input logic [103:0] k);
        exp_t e;
        e.id = 16'hFFFF;
        e.hit = 1'b0;
        e.acc = 0;
        for (int r = 0; r < NR; r++) begin
            if (m_valid[r] && ((k ^ m_key[r]) & m_mask[r]) == '0) begin
                e.id = 16'(r);
                e.hit = 1'b1;
                return e;
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] model_read(input int r, input logic [7:0] sel);
        logic [127:0] t;
        int w;
        w = int'(sel[3:0]);
        if (sel == 8'h00) return {31'b0, m_valid[r]};
        if (sel == 8'h01) return CNT_EN ? m_cnt[r] : 32'h0;
        if (sel[7:4] == 4'h1 && w < 4) begin
            t = {24'b0, m_key[r]};
            return t[w*32 +: 32];
        end
        if (sel[7:4] == 4'h2 && w < 4) begin
            t = {24'b0, m_mask[r]};
            return t[w*32 +: 32];
        end
        return 32'h0;
    endfunction

    task automatic model_write(input int r, input logic [7:0] sel, input logic [31:0] d);
        logic [127:0] t;
        int w;
        w = int'(sel[3:0]);
        if (sel == 8'h00) m_valid[r] = d[0];
        if (sel == 8'h01 && CNT_EN) m_cnt[r] = d;
        if (sel[7:4] == 4'h1 && w < 4) begin
            t = {24'b0, m_key[r]};
            t[w*32 +: 32] = d;
            m_key[r] = t[103:0];
        end
        if (sel[7:4] == 4'h2 && w < 4) begin
            t = {24'b0, m_mask[r]};
            t[w*32 +: 32] = d;
            m_mask[r] = t[103:0];
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < NR; r++) begin
            m_valid[r] = 1'b0;
            m_key[r]   = '0;
            m_mask[r]  = '0;
            m_cnt[r]   = '0;
        end
        q.delete();
    endtask

    // One clock: drive at the falling edge, observe, then update the model for the coming edge.
    task automatic step_cfg(input bit kv, input logic [103:0] k, input bit rdy, input bit cv,
                            input bit cwr, input logic [3:0] crule, input logic [7:0] csel,
                            input logic [31:0] cdata);
        exp_t e;
        @(negedge clk);
        key_valid = kv;
        key = k;
        s_out_ready = rdy;
        cfg_valid = cv;
        cfg_wr = cwr;
        cfg_rule = crule;
        cfg_sel = csel;
        cfg_wdata = cdata;
        #1;
        cyc++;
        rsp_v = cfg_rsp_valid;
        rsp_d = cfg_rdata;
        kr_s = key_ready;
        if (ruleID_valid) seen_valid = 1'b1;
        if (ruleID_valid && q.size() == 0) check("spurious_result", 1, 0);
        if (ruleID_valid && q.size() != 0) begin
            check("ruleID", ruleID, q[0].id);
            check("hit", hit, q[0].hit);
            if (rdy) begin
                if (lat_check) check("latency", cyc - q[0].acc, 2);
                last_id = ruleID;
                last_hit = hit;
                if (CNT_EN && q[0].hit && m_cnt[q[0].id] != 32'hFFFFFFFF) m_cnt[q[0].id]++;
                void'(q.pop_front());
            end
        end
        if (rdy) check("key_ready_free", key_ready, 1);
        if (kv && key_ready) begin
            e = model_lookup(k);
            e.acc = cyc;
            q.push_back(e);
        end
        if (cv && !cwr) rd_exp = model_read(int'(crule), csel);
        if (cv && cwr) model_write(int'(crule), csel, cdata);
    endtask

    task automatic step(input bit kv, input logic [103:0] k, input bit rdy);
        step_cfg(kv, k, rdy, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic cfg_write(input logic [3:0] r, input logic [7:0] s, input logic [31:0] d);
        step_cfg(1'b0, '0, 1'b1, 1'b1, 1'b1, r, s, d);
    endtask

    task automatic cfg_read(input logic [3:0] r, input logic [7:0] s, input string tag);
        logic [31:0] e;
        step_cfg(1'b0, '0, 1'b1, 1'b1, 1'b0, r, s, '0);
        e = rd_exp;
        step(1'b0, '0, 1'b1);
        check({tag, "_rsp_valid"}, rsp_v, 1);
        check(tag, rsp_d, e);
    endtask

    task automatic prog_rule(input logic [3:0] r, input bit v, input logic [103:0] k,
                             input logic [103:0] m);
        logic [127:0] tk, tm;
        tk = {24'b0, k};
        tm = {24'b0, m};
        for (int w = 0; w < 4; w++) begin
            cfg_write(r, 8'h10 + 8'(w), tk[w*32 +: 32]);
            cfg_write(r, 8'h20 + 8'(w), tm[w*32 +: 32]);
        end
        cfg_write(r, 8'h00, {31'b0, v});
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, '0, 1'b1);
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [103:0] k, kab, k52, k11;
        int r;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_ruleID_valid", ruleID_valid, 0);
        check("rst_hit", hit, 0);
        check("rst_ruleID", ruleID, 16'hFFFF);
        check("rst_rsp_valid", cfg_rsp_valid, 0);
        check("rst_rdata", cfg_rdata, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("key_ready_after_release", key_ready, 1);

        lat_check = 1'b1;
        kab = rand104();
        kab[7:0] = 8'hAB;
        cfg_write(3, 8'h10, 32'hAB);
        cfg_write(3, 8'h20, 32'hFF);
        cfg_write(3, 8'h00, 32'h1);
        step(1'b1, kab, 1'b1);
        drain();
        check("single_rule_id", last_id, 3);
        check("single_rule_hit", last_hit, 1);

        k52 = rand104();
        k52[7:0] = 8'h52;
        cfg_write(2, 8'h10, 32'h02);
        cfg_write(2, 8'h20, 32'h0F);
        cfg_write(2, 8'h00, 32'h1);
        cfg_write(5, 8'h10, 32'h50);
        cfg_write(5, 8'h20, 32'hF0);
        cfg_write(5, 8'h00, 32'h1);
        step(1'b1, k52, 1'b1);
        drain();
        check("multi_hit_lowest", last_id, 2);
        cfg_write(2, 8'h00, 32'h0);
        step(1'b1, k52, 1'b1);
        drain();
        check("multi_hit_after_clear", last_id, 5);

        cfg_write(3, 8'h00, 32'h0);
        cfg_write(5, 8'h00, 32'h0);
        step(1'b1, rand104(), 1'b1);
        drain();
        check("miss_id", last_id, 16'hFFFF);
        check("miss_hit", last_hit, 0);

        cfg_write(3, 8'h14, 32'h1234);
        cfg_write(3, 8'h30, 32'h5678);
        cfg_read(3, 8'h14, "oor_read");
        cfg_read(3, 8'h10, "key_w0_kept");
        step(1'b0, '0, 1'b1);
        check("rsp_pulse_one_cycle", rsp_v, 0);
        cfg_write(3, 8'h13, 32'hFFFFFFFF);
        cfg_read(3, 8'h13, "key_w3_trunc");
        cfg_write(3, 8'h13, 32'h0);
        cfg_read(3, 8'h01, "cnt_read");

        step_cfg(1'b1, kab, 1'b1, 1'b1, 1'b1, 3, 8'h00, 32'h1);
        step(1'b1, kab, 1'b1);
        drain();
        check("cfg_after_same_edge_id", last_id, 3);

        lat_check = 1'b0;
        cfg_write(5, 8'h00, 32'h1);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, (i % 2 == 0) ? kab : k52, 1'b0);
            if (i >= 2) check("stall_key_ready", kr_s, 0);
        end
        for (int i = 0; i < 4; i++) step(1'b1, (i % 2 == 0) ? k52 : kab, 1'b1);
        drain();
        cfg_read(3, 8'h01, "cnt_rule3");
        cfg_read(5, 8'h01, "cnt_rule5");

        k11 = rand104();
        k11[7:0] = 8'h11;
        cfg_write(1, 8'h10, 32'h11);
        cfg_write(1, 8'h20, 32'hFF);
        cfg_write(1, 8'h00, 32'h1);
        cfg_write(1, 8'h01, 32'hFFFFFFFE);
        for (int i = 0; i < 3; i++) step(1'b1, k11, 1'b1);
        drain();
        cfg_read(1, 8'h01, "cnt_saturate");
        cfg_write(1, 8'h01, 32'h5);
        step(1'b1, k11, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step_cfg(1'b0, '0, 1'b1, 1'b1, 1'b1, 1, 8'h01, 32'h1234);
        drain();
        cfg_read(1, 8'h01, "cnt_write_priority");

        for (int i = 0; i < NR; i++) begin
            prog_rule(4'(i), ($urandom_range(0, 3) != 0), rand104(),
                      rand104() & rand104() & rand104());
        end
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, NR - 1);
            k = ($urandom_range(0, 1) == 1) ? (m_key[r] ^ (rand104() & ~m_mask[r])) : rand104();
            step($urandom_range(0, 3) != 0, k, $urandom_range(0, 9) < 7);
        end
        drain();
        for (int i = 0; i < NR; i += 5) cfg_read(4'(i), 8'h01, "cnt_random");

        step(1'b1, rand104(), 1'b1);
        step(1'b1, rand104(), 1'b1);
        @(negedge clk);
        reset = 1'b0;
        key_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_clear();
        seen_valid = 1'b0;
        repeat (6) step(1'b0, '0, 1'b1);
        check("no_result_after_reset", seen_valid, 0);
        for (int i = 0; i < NR; i++) begin
            cfg_read(4'(i), 8'h00, "rst_ctrl");
            cfg_read(4'(i), 8'h01, "rst_cnt");
            for (int w = 0; w < 4; w++) begin
                cfg_read(4'(i), 8'h10 + 8'(w), "rst_key");
                cfg_read(4'(i), 8'h20 + 8'(w), "rst_mask");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_tcam.md
PARAM_TCAM -- requirements
Module: param_tcam

Interface
REQ-001 SHALL have parameter N_RULES, 16, number of rules, a power of two from 2 to 64.
REQ-002 SHALL have parameter W_KEY, 104, key and mask width in bits.
REQ-003 SHALL have parameter W_RULEID, 16, ruleID output width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: port clk input 1, rising-edge clock; port reset input 1, asynchronous active-low reset.
REQ-005 SHALL have key_valid input 1, lookup request.
REQ-006 SHALL have key input W_KEY, lookup key.
REQ-007 SHALL have key_ready output 1, lookup accepted when high together with key_valid.
REQ-008 SHALL have ruleID_valid output 1, result valid.
REQ-009 SHALL have ruleID output W_RULEID, matching rule index, or all ones on miss.
REQ-010 SHALL have hit output 1, at least one rule matched.
REQ-011 SHALL have s_out_ready input 1, downstream accepts the result.
REQ-012 SHALL have cfg_valid input 1, config access strobe, single cycle.
REQ-013 SHALL have cfg_wr input 1, 1 selects write and 0 selects read.
REQ-014 SHALL have cfg_rule input $clog2(N_RULES), target rule index.
REQ-015 SHALL have cfg_sel input 8, word select: 0x00 ctrl (bit0 = rule valid); 0x01 hit counter; 0x10+w key word w; 0x20+w mask word w; w ranges over 0..ceil(W_KEY/32)-1.
REQ-016 SHALL have cfg_wdata input 32, write data, LSB-aligned; bits beyond W_KEY in the last word are ignored.
REQ-017 SHALL have cfg_rsp_valid output 1, read response strobe.
REQ-018 SHALL have cfg_rdata output 32, read data; unused bits read as 0.

Function
REQ-019 SHALL treat rule r as a match iff valid[r]=1 and (key & mask[r]) == (keyval[r] & mask[r]).
REQ-020 SHALL be a 2-stage pipeline: stage 1 registers the match bitmap; stage 2 registers hit, ruleID and ruleID_valid; latency is 2 cycles when unstalled.
REQ-021 SHALL select the lowest matching index on multiple hits.
REQ-022 SHALL drive ruleID with all ones and hit=0 on a miss.
REQ-023 SHALL compute key_ready = !(ruleID_valid && !s_out_ready) combinationally; both stages advance only when key_ready=1.
REQ-024 SHALL hold ruleID, hit and ruleID_valid stable while stalled, with no result lost or duplicated.
REQ-025 SHALL insert a bubble (stage valid 0) when the pipeline advances with key_valid=0.
REQ-026 SHALL apply config writes on the cycle after cfg_valid; a lookup in stage 1 on that same edge uses the old rule contents.
REQ-027 SHALL pulse cfg_rsp_valid for exactly 1 cycle, one cycle after a read, carrying the current contents.
REQ-028 SHALL treat an access with cfg_sel outside the decoded range as follows: a write has no effect; a read returns 0 with cfg_rsp_valid still asserted.
REQ-029 SHALL increment the 32-bit counter of rule ruleID when ruleID_valid && hit && s_out_ready, once per delivered result.
REQ-030 SHALL saturate each counter at 0xFFFFFFFF.
REQ-031 SHALL give a counter write priority over an increment in the same cycle.
REQ-032 SHALL not clear the rule's counter when the rule is written (any word, including ctrl).

Reset
REQ-033 SHALL clear, on reset assertion: all rules (valid, key, mask = 0), all counters, both pipeline stages, ruleID_valid=0, hit=0, ruleID=all ones, cfg_rsp_valid=0, cfg_rdata=0.
REQ-034 SHALL drop in-flight lookups when reset is asserted mid-operation; no result emerges after release.
REQ-035 SHALL drive key_ready=1 one cycle after reset release.

Configuration
REQ-036 SHALL compile hit counters, the increment logic and cfg_sel 0x01 in when macro PARAM_TCAM_COUNTER_EN is defined.
REQ-037 SHALL, with PARAM_TCAM_COUNTER_EN undefined, remove counter storage; a read of cfg_sel 0x01 returns 0 and a write to it is ignored.

Structure
REQ-038 SHALL place the cfg_sel encodings (SEL_CTRL, SEL_CNT, SEL_KEY_BASE, SEL_MASK_BASE) and a rule-word-count function in shared package usg_tcam_pkg.
REQ-039 SHALL implement the lowest-index priority encoder as sub-module tcam_prio_enc, parametrised by N_RULES and producing a hit flag and an index.

Verification
REQ-040 SHALL cover: rule 3 key=0xAB in the low byte, mask=0xFF, valid=1; lookup key 0xAB -> 2 cycles later ruleID=3, hit=1.
REQ-041 SHALL cover: rules 2 and 5 both match -> ruleID=2; clear rule 2 valid -> ruleID=5.
REQ-042 SHALL cover: no valid rules -> ruleID=0xFFFF, hit=0, ruleID_valid=1.
REQ-043 SHALL cover: s_out_ready=0 for 5 cycles with back-to-back keys -> key_ready=0, result held, all results delivered in order, counters increment once each.
REQ-044 SHALL cover: write counter of rule 1 = 0xFFFFFFFE, then 3 hits on rule 1 -> read returns 0xFFFFFFFF; counter write and hit in the same cycle -> written value kept.
REQ-045 SHALL cover: reset asserted with 2 lookups in flight -> no ruleID_valid after release, all rules read back 0.
